line_data_memory: RTL and testbench

//  Off-chip data memory serving the data cache's line-refill / write-back port.

---
 rtl/line_data_memory.sv | 120 ++++++++++++
 tb/tb_line_data_memory.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_data_memory.sv
// -----------------------------------------------------------------------------
// line_data_memory
//   Off-chip line memory behind the data cache refill / write-back port.
//   One 256-bit line request (read or write) is accepted at a time and
//   completed after a fixed LATENCY with a single-cycle ack strobe.
//
// Ports
//   clk_i     in   1       clock, rising edge
//   rst_i     in   1       asynchronous reset, active-low
//   addr_i    in   32      byte address of the line; bits [4:0] ignored
//   data_i    in   LINE_W  write line data
//   enable_i  in   1       request valid
//   write_i   in   1       1 = write line, 0 = read line
//   data_o    out  LINE_W  read line data, held until the next read completes
//   ack_o     out  1       one-cycle completion strobe
// -----------------------------------------------------------------------------
module line_data_memory #(
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic [LINE_W-1:0] data_o,
  output logic              ack_o
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e              state_q;
  logic [7:0]          cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic                wr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [LINE_W-1:0]   rdata_q;
  logic                ack_q;

  // Line storage; deliberately not reset so contents survive a reset.
  logic [LINE_W-1:0]   mem_q [DEPTH];

  logic                done_d;
  logic                mem_we_d;

  // Only the line index is decoded; byte offset and upper bits alias.
  logic                unused_addr;
  assign unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

  // Last WAIT edge: the transaction completes on this edge.
  assign done_d   = (state_q == S_WAIT) && (cnt_q == 8'd1);
  assign mem_we_d = done_d && wr_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= 1'b0;
          if (enable_i) begin
            idx_q   <= addr_i[IDX_W+4:5];
            wr_q    <= write_i;
            wdata_q <= data_i;
            cnt_q   <= 8'(LATENCY - 1);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Inputs are ignored here; the latched request is used.
          if (done_d) begin
            cnt_q   <= 8'd0;
            ack_q   <= 1'b1;
            state_q <= S_ACK;
            if (!wr_q) begin
              rdata_q <= mem_q[idx_q];
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_ACK: begin
          // No request can be accepted in the ack cycle.
          ack_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Array write lands on the edge entering ACK. A reset before that edge
  // forces IDLE, so an aborted write never reaches the array.
  always_ff @(posedge clk_i) begin
    if (mem_we_d) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign data_o = rdata_q;
  assign ack_o  = ack_q;

endmodule

// File: tb/tb_line_data_memory.sv
module tb_line_data_memory;

  localparam int LW = 256;
  localparam int L  = 10;

  logic          clk_i;
  logic          rst_i;
  logic [31:0]   addr_i;
  logic [LW-1:0] data_i;
  logic          enable_i;
  logic          write_i;
  logic [LW-1:0] data_o;
  logic          ack_o;

  line_data_memory #(.LINE_W(LW), .DEPTH(512), .LATENCY(L)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .enable_i(enable_i),
    .write_i (write_i),
    .data_o  (data_o),
    .ack_o   (ack_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [LW-1:0] data;
    string         name;
  } exp_t;

  typedef struct {
    bit            wr;
    logic [31:0]   addr;
    logic [LW-1:0] data;
    logic [LW-1:0] exp;
    string         name;
  } vec_t;

  exp_t          sbq[$];
  vec_t          vt[12];
  logic [LW-1:0] last_rd;
  int            n_chk = 0;
  int            n_fail = 0;
  int            ack_seen = 0;

  logic [LW-1:0] pA, pB, pC, pD, pE, pF;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack pops one expectation (completion cycle and data_o).
  always @(posedge clk_i) begin
    #1;
    if (rst_i === 1'b1 && ack_o === 1'b1) begin
      ack_seen++;
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack at cycle %0d actual=1 expected=0", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.name, "_cycle"}, LW'(cyc), LW'(e.cyc));
        chk({e.name, "_data"}, data_o, e.data);
      end
    end
  end

  task automatic req(input bit wr, input logic [31:0] a, input logic [LW-1:0] d,
                     input logic [LW-1:0] exp, input string nm);
    exp_t e;
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = wr;
    addr_i   = a;
    data_i   = d;
    if (!wr) last_rd = exp;
    e.cyc  = cyc + L;
    e.data = last_rd;
    e.name = nm;
    sbq.push_back(e);
    @(negedge clk_i);
    enable_i = 1'b0;
  endtask

  task automatic drain(input bit scramble, input string nm);
    int left;
    left = 4 * L + 10;
    while (sbq.size() != 0 && left > 0) begin
      @(negedge clk_i);
      if (scramble) begin
        addr_i  = $urandom;
        data_i  = {8{$urandom}};
        write_i = 1'($urandom_range(0, 1));
      end
      left--;
    end
    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout actual=no_ack expected=ack pending=%0d", nm, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    pA = {8{32'hA5A5_0003}};
    pB = {8{32'h1234_5678}};
    pC = {8{32'hC0FF_EE00}};
    pD = {8{32'h0BAD_F00D}};
    pE = {8{32'h5EED_1E55}};
    pF = {8{32'hFFFF_0000}};

    vt[0]  = '{1'b1, 32'h0000_0040, {8{32'hDEADBEEF}}, '0, "w_40"};
    vt[1]  = '{1'b0, 32'h0000_0040, '0, {8{32'hDEADBEEF}}, "r_40"};
    vt[2]  = '{1'b1, 32'h0000_4020, pB, '0, "w_4020"};
    vt[3]  = '{1'b0, 32'h0000_0020, '0, pB, "r_alias_20"};
    vt[4]  = '{1'b0, 32'h0000_003F, '0, pB, "r_lowbits_3f"};
    vt[5]  = '{1'b1, 32'h0000_0060, pA, '0, "w_idx3_A"};
    vt[6]  = '{1'b0, 32'h0000_0060, '0, pA, "r_idx3_A"};
    vt[7]  = '{1'b1, 32'h0000_0040, pC, '0, "w_40_over"};
    vt[8]  = '{1'b0, 32'h0000_0040, '0, pC, "r_40_new"};
    vt[9]  = '{1'b0, 32'h0000_0020, '0, pB, "r_20_kept"};
    vt[10] = '{1'b1, 32'h0000_3FE0, pD, '0, "w_idx511"};
    vt[11] = '{1'b0, 32'hFFFF_FFE0, '0, pD, "r_idx511_alias"};

    rst_i    = 1'b1;
    enable_i = 1'b0;
    write_i  = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    last_rd  = '0;

    // Power-on reset, asserted between edges.
    #3 rst_i = 1'b0;
    #1;
    chk("por_ack", LW'(ack_o), LW'(0));
    chk("por_data", data_o, '0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    // Vector table: latency, aliasing, low address bits, overwrite, data_o hold on writes.
    for (int i = 0; i < 12; i++) begin
      req(vt[i].wr, vt[i].addr, vt[i].data, vt[i].exp, vt[i].name);
      drain(1'b0, vt[i].name);
    end

    // Inputs wiggle every cycle while the request waits.
    req(1'b1, 32'h0000_00A0, pE, '0, "w_scramble");
    drain(1'b1, "w_scramble");
    req(1'b0, 32'h0000_00A0, '0, pE, "r_scramble");
    drain(1'b1, "r_scramble");

    // Held enable: second read is accepted on the first IDLE edge after the ack.
    begin
      exp_t e1, e2;
      int left;
      @(negedge clk_i);
      enable_i = 1'b1;
      write_i  = 1'b0;
      addr_i   = 32'h0000_0040;
      data_i   = '0;
      last_rd  = pC;
      e1.cyc = cyc + L;         e1.data = pC; e1.name = "held_1";
      e2.cyc = cyc + 2 * L + 1; e2.data = pC; e2.name = "held_2";
      sbq.push_back(e1);
      sbq.push_back(e2);
      left = 3 * L;
      while (sbq.size() > 1 && left > 0) begin
        @(negedge clk_i);
        left--;
      end
      repeat (2) @(negedge clk_i);
      enable_i = 1'b0;
      drain(1'b0, "held");
    end

    // Asynchronous reset mid-cycle clears outputs immediately.
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    #1;
    chk("midcyc_rst_ack", LW'(ack_o), LW'(0));
    chk("midcyc_rst_data", data_o, '0);
    last_rd = '0;
    @(negedge clk_i);
    rst_i = 1'b1;

    // Reset during WAIT of a write to idx 3 aborts it: no ack, old line kept.
    begin
      int a0;
      @(negedge clk_i);
      enable_i = 1'b1;
      write_i  = 1'b1;
      addr_i   = 32'h0000_0060;
      data_i   = pF;
      @(negedge clk_i);
      enable_i = 1'b0;
      repeat (4) @(negedge clk_i);
      #2 rst_i = 1'b0;
      #1;
      chk("abort_rst_ack", LW'(ack_o), LW'(0));
      @(negedge clk_i);
      rst_i = 1'b1;
      a0 = ack_seen;
      repeat (L + 5) @(negedge clk_i);
      chk("abort_no_ack", LW'(ack_seen), LW'(a0));
      req(1'b0, 32'h0000_0060, '0, pA, "r_after_abort");
      drain(1'b0, "r_after_abort");
    end

    repeat (3) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
